// File: rtl/i2c_rx_byte_buffer.sv
// ----------------------------------------------------------------------------
// i2c_rx_byte_buffer
//
// I2C receive deserializer and byte buffer. SDA is synchronised (and optionally
// glitch-filtered), then shifted in MSB-first on qualified SHIFT_IN pulses. The
// 8th bit of each byte writes the byte into the next free buffer slot at the
// same clock edge. Up to MAX_BYTES bytes are kept in arrival order. Once the
// buffer is full, further completed bytes are dropped and flagged by a sticky
// OVERFLOW.
//
// Optional feature macro: I2C_RX_GLITCH_FILTER_EN
//   defined   : sda_f follows the synced SDA only after FILTER_LEN consecutive
//               differing cycles (pad-to-sda_f latency 2 + FILTER_LEN)
//   undefined : sda_f is the synchronizer output (latency 2)
//
// Ports
//   CLK           system clock
//   RST           synchronous reset, active high
//   CLK_EN        bit-rate enable, qualifies SHIFT_IN and BIT_RST
//   SHIFT_IN      shift filtered SDA into the shift register
//   BIT_RST       realign bit counter and clear shifter (START / repeated START)
//   CLEAR         clear buffer, count, overflow and shifter (not gated by CLK_EN)
//   SDA_IN        raw SDA from the pad
//   I2C_DATA_REC  byte k at [8k+7:8k], byte 0 received first
//   BYTE_CNT      number of stored bytes (saturates at MAX_BYTES)
//   BYTE_STB      one-cycle pulse after a byte is written
//   PARTIAL       a byte is in progress (bit counter != 0)
//   OVERFLOW      sticky: a byte completed while the buffer was full
// ----------------------------------------------------------------------------
module i2c_rx_byte_buffer #(
    parameter  int unsigned MAX_BYTES  = 31,
    parameter  int unsigned FILTER_LEN = 3,
    localparam int unsigned CNT_W      = $clog2(MAX_BYTES + 1)
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   CLK_EN,
    input  logic                   SHIFT_IN,
    input  logic                   BIT_RST,
    input  logic                   CLEAR,
    input  logic                   SDA_IN,
    output logic [8*MAX_BYTES-1:0] I2C_DATA_REC,
    output logic [CNT_W-1:0]       BYTE_CNT,
    output logic                   BYTE_STB,
    output logic                   PARTIAL,
    output logic                   OVERFLOW
);

    if (MAX_BYTES < 1 || MAX_BYTES > 64) begin : g_bad_max_bytes
        $error("MAX_BYTES must be in 1..64");
    end
    if (FILTER_LEN < 1 || FILTER_LEN > 15) begin : g_bad_filter_len
        $error("FILTER_LEN must be in 1..15");
    end

    typedef enum logic [1:0] {
        StEmpty,
        StRecv,
        StFull
    } state_e;

    // ------------------------------------------------------------------
    // SDA synchronizer and optional glitch filter
    // ------------------------------------------------------------------
    logic [1:0] sda_sync_q, sda_sync_d;
    logic       sda_f;

    assign sda_sync_d = {sda_sync_q[0], SDA_IN};

    always_ff @(posedge CLK) begin
        if (RST) begin
            sda_sync_q <= 2'b11;
        end else begin
            sda_sync_q <= sda_sync_d;
        end
    end

`ifdef I2C_RX_GLITCH_FILTER_EN
    logic       sda_f_q, sda_f_d;
    logic [3:0] flt_cnt_q, flt_cnt_d;

    // Count consecutive cycles the synced value disagrees with sda_f; any
    // agreement restarts the count, so short pulses never propagate.
    always_comb begin
        sda_f_d   = sda_f_q;
        flt_cnt_d = 4'd0;
        if (sda_sync_q[1] != sda_f_q) begin
            if (flt_cnt_q == 4'(FILTER_LEN - 1)) begin
                sda_f_d = sda_sync_q[1];
            end else begin
                flt_cnt_d = flt_cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            sda_f_q   <= 1'b1;
            flt_cnt_q <= 4'd0;
        end else begin
            sda_f_q   <= sda_f_d;
            flt_cnt_q <= flt_cnt_d;
        end
    end

    assign sda_f = sda_f_q;
`else
    assign sda_f = sda_sync_q[1];
`endif

    // ------------------------------------------------------------------
    // Shifter, bit counter, buffer and fill-state FSM
    // ------------------------------------------------------------------
    state_e                 state_q, state_d;
    // Only 7 bits are kept: the 8th bit goes straight into the buffer.
    logic [6:0]             shreg_q, shreg_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [8*MAX_BYTES-1:0] data_q, data_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   stb_q, stb_d;
    logic                   ovf_q, ovf_d;
    logic [7:0]             byte_w;

    assign byte_w = {shreg_q, sda_f};

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        data_d    = data_q;
        cnt_d     = cnt_q;
        stb_d     = 1'b0;
        ovf_d     = ovf_q;

        if (CLEAR) begin
            // A byte completing on this edge is intentionally lost.
            state_d   = StEmpty;
            shreg_d   = '0;
            bit_cnt_d = '0;
            data_d    = '0;
            cnt_d     = '0;
            ovf_d     = 1'b0;
        end else if (CLK_EN && BIT_RST) begin
            shreg_d   = '0;
            bit_cnt_d = '0;
        end else if (CLK_EN && SHIFT_IN) begin
            shreg_d   = byte_w[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
                if (state_q == StFull) begin
                    ovf_d = 1'b1;
                end else begin
                    for (int k = 0; k < int'(MAX_BYTES); k++) begin
                        if (cnt_q == CNT_W'(k)) begin
                            data_d[8*k +: 8] = byte_w;
                        end
                    end
                    cnt_d   = cnt_q + 1'b1;
                    stb_d   = 1'b1;
                    state_d = (cnt_q == CNT_W'(MAX_BYTES - 1)) ? StFull : StRecv;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= StEmpty;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            data_q    <= '0;
            cnt_q     <= '0;
            stb_q     <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            data_q    <= data_d;
            cnt_q     <= cnt_d;
            stb_q     <= stb_d;
            ovf_q     <= ovf_d;
        end
    end

    assign I2C_DATA_REC = data_q;
    assign BYTE_CNT     = cnt_q;
    assign BYTE_STB     = stb_q;
    assign PARTIAL      = (bit_cnt_q != 3'd0);
    assign OVERFLOW     = ovf_q;

endmodule
